// File: rtl/w0rm_core_imem_port.sv
// w0rm_core_imem_port
// Instruction-side memory responder for the W0RM core. Serves one 16-bit
// instruction per halfword-aligned PC request, using a single-word line
// buffer for back-to-back halfwords in the same 32-bit word. Misses are
// fetched over a simple request/response bus; a branch flush suppresses the
// output of any outstanding fetch while still letting the buffer fill.
//
// Ports:
//   clk, reset        clock, synchronous active-high reset
//   pc_in, pc_valid   fetch request (pc_in bit 0 ignored)
//   pc_ready          request accepted this cycle (IDLE and not in reset)
//   flush             branch flush, cancels output of outstanding request
//   buf_invalidate    clears the line buffer
//   inst_data_out, inst_addr_out, inst_valid_out   returned instruction
//   mem_req, mem_addr, mem_ready                   bus read request
//   mem_rdata, mem_rvalid                          bus read response
//
// state  | meaning
// S_IDLE | accepting requests, hits served from the line buffer
// S_REQ  | miss request presented on the bus, waiting for mem_ready
// S_WAIT | request accepted, waiting for mem_rvalid
module w0rm_core_imem_port #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int INST_WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [ADDR_WIDTH-1:0] pc_in,
  input  logic                  pc_valid,
  output logic                  pc_ready,
  input  logic                  flush,
  input  logic                  buf_invalidate,
  output logic [INST_WIDTH-1:0] inst_data_out,
  output logic                  inst_valid_out,
  output logic [ADDR_WIDTH-1:0] inst_addr_out,
  output logic                  mem_req,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  input  logic                  mem_ready,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  input  logic                  mem_rvalid
);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT} state_t;

  state_t                state_q, state_d;
  logic [ADDR_WIDTH-3:0] buf_tag_q, buf_tag_d;
  logic [DATA_WIDTH-1:0] buf_data_q, buf_data_d;
  logic                  buf_valid_q, buf_valid_d;
  logic                  drop_q, drop_d;
  logic                  pend_half_q, pend_half_d;
  logic [ADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;
  logic [INST_WIDTH-1:0] inst_data_q, inst_data_d;
  logic [ADDR_WIDTH-1:0] inst_addr_q, inst_addr_d;
  logic                  inst_valid_q, inst_valid_d;

  logic buf_hit;
  logic deliver;
  logic unused_pc_bit0;

  assign unused_pc_bit0 = pc_in[0];

  // Little-endian halfword select: hi=0 -> low half, hi=1 -> high half.
  function automatic logic [INST_WIDTH-1:0] half_sel(input logic [DATA_WIDTH-1:0] w,
                                                     input logic hi);
    return hi ? w[DATA_WIDTH-1:INST_WIDTH] : w[INST_WIDTH-1:0];
  endfunction

  assign buf_hit = buf_valid_q && (buf_tag_q == pc_in[ADDR_WIDTH-1:2]);
  // A flush on the very edge the data returns also cancels the output.
  assign deliver = !(drop_q || flush);

  always_comb begin
    state_d      = state_q;
    buf_tag_d    = buf_tag_q;
    buf_data_d   = buf_data_q;
    buf_valid_d  = buf_valid_q;
    drop_d       = drop_q;
    pend_half_d  = pend_half_q;
    mem_addr_d   = mem_addr_q;
    inst_data_d  = inst_data_q;
    inst_addr_d  = inst_addr_q;
    inst_valid_d = 1'b0;

    if (buf_invalidate) buf_valid_d = 1'b0;

    case (state_q)
      S_IDLE: begin
        drop_d = 1'b0;
        if (pc_valid && !flush) begin
          if (buf_hit) begin
            // Served from current buffer contents even if invalidated now.
            inst_data_d  = half_sel(buf_data_q, pc_in[1]);
            inst_addr_d  = {pc_in[ADDR_WIDTH-1:1], 1'b0};
            inst_valid_d = 1'b1;
          end else begin
            mem_addr_d  = {pc_in[ADDR_WIDTH-1:2], 2'b00};
            pend_half_d = pc_in[1];
            state_d     = S_REQ;
          end
        end
      end
      S_REQ: begin
        if (flush) drop_d = 1'b1;
        if (mem_ready) state_d = S_WAIT;
      end
      S_WAIT: begin
        if (flush) drop_d = 1'b1;
        if (mem_rvalid) begin
          buf_data_d  = mem_rdata;
          buf_tag_d   = mem_addr_q[ADDR_WIDTH-1:2];
          buf_valid_d = !buf_invalidate;
          if (deliver) begin
            inst_data_d  = half_sel(mem_rdata, pend_half_q);
            inst_addr_d  = {mem_addr_q[ADDR_WIDTH-1:2], pend_half_q, 1'b0};
            inst_valid_d = 1'b1;
          end
          drop_d  = 1'b0;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= S_IDLE;
      buf_tag_q    <= '0;
      buf_data_q   <= '0;
      buf_valid_q  <= 1'b0;
      drop_q       <= 1'b0;
      pend_half_q  <= 1'b0;
      mem_addr_q   <= '0;
      inst_data_q  <= '0;
      inst_addr_q  <= '0;
      inst_valid_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      buf_tag_q    <= buf_tag_d;
      buf_data_q   <= buf_data_d;
      buf_valid_q  <= buf_valid_d;
      drop_q       <= drop_d;
      pend_half_q  <= pend_half_d;
      mem_addr_q   <= mem_addr_d;
      inst_data_q  <= inst_data_d;
      inst_addr_q  <= inst_addr_d;
      inst_valid_q <= inst_valid_d;
    end
  end

  assign pc_ready       = (state_q == S_IDLE) && !reset;
  assign mem_req        = (state_q == S_REQ);
  assign mem_addr       = mem_addr_q;
  assign inst_data_out  = inst_data_q;
  assign inst_addr_out  = inst_addr_q;
  assign inst_valid_out = inst_valid_q;

endmodule

// File: tb/tb_w0rm_core_imem_port.sv
// Bench for w0rm_core_imem_port: table of fetch records plus hand-written
// corner sequences; expected instructions go to a scoreboard queue when a
// request is driven and are popped when inst_valid_out is seen.
module tb_w0rm_core_imem_port;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] pc_in;
  logic        pc_valid;
  logic        pc_ready;
  logic        flush;
  logic        buf_invalidate;
  logic [15:0] inst_data_out;
  logic        inst_valid_out;
  logic [31:0] inst_addr_out;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_ready;
  logic [31:0] mem_rdata;
  logic        mem_rvalid;

  w0rm_core_imem_port dut (
    .clk(clk), .reset(reset), .pc_in(pc_in), .pc_valid(pc_valid),
    .pc_ready(pc_ready), .flush(flush), .buf_invalidate(buf_invalidate),
    .inst_data_out(inst_data_out), .inst_valid_out(inst_valid_out),
    .inst_addr_out(inst_addr_out), .mem_req(mem_req), .mem_addr(mem_addr),
    .mem_ready(mem_ready), .mem_rdata(mem_rdata), .mem_rvalid(mem_rvalid)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] d;
    logic [31:0] a;
  } exp_t;

  typedef struct {
    logic [31:0] pc;
    bit          hit;
    int          rdly;
    int          rvdly;
    logic [15:0] data;
  } vec_t;

  exp_t sb[$];
  int   errors = 0;
  int   checks = 0;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    case (a)
      32'h2000_0000: return 32'hBEEF_1234;
      32'h2000_0010: return 32'hCAFE_5678;
      32'h2000_0020: return 32'h0BAD_F00D;
      32'h2000_0100: return 32'h1357_9BDF;
      default:       return {16'hA5A5, a[15:0]};
    endcase
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chkb(input string name, input logic act, input logic exp);
    chk(name, {31'b0, act}, {31'b0, exp});
  endtask

  // Scoreboard consumer: every strobe must match the oldest expectation.
  always @(negedge clk) begin
    if (inst_valid_out === 1'b1) begin
      if (sb.size() == 0) begin
        chkb("unexpected_valid", inst_valid_out, 1'b0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("inst_data", {16'b0, inst_data_out}, {16'b0, e.d});
        chk("inst_addr", inst_addr_out, e.a);
      end
    end
  end

  task automatic fetch(input logic [31:0] pc, input bit exp_hit, input int rdly,
                       input int rvdly, input bit flush_wait, input bit inval_fill,
                       input logic [15:0] exp_data);
    exp_t        e;
    logic [31:0] a0;
    a0       = {pc[31:2], 2'b00};
    pc_in    = pc;
    pc_valid = 1'b1;
    if (!flush_wait) begin
      e.d = exp_data;
      e.a = {pc[31:1], 1'b0};
      sb.push_back(e);
    end
    @(posedge clk); #1;
    pc_valid = 1'b0;
    chkb("miss_issues_req", mem_req, !exp_hit);
    if (exp_hit) begin
      chkb("hit_latency", inst_valid_out, 1'b1);
      return;
    end
    chk("mem_addr", mem_addr, a0);
    chkb("pc_ready_busy", pc_ready, 1'b0);
    for (int i = 0; i < rdly; i++) begin
      @(posedge clk); #1;
      chkb("stall_req", mem_req, 1'b1);
      chk("stall_addr", mem_addr, a0);
      chkb("stall_ready", pc_ready, 1'b0);
    end
    mem_ready = 1'b1;
    @(posedge clk); #1;
    mem_ready = 1'b0;
    for (int i = 1; i < rvdly; i++) begin
      if (i == 1) flush = flush_wait;
      @(posedge clk); #1;
      flush = 1'b0;
      chkb("wait_req_low", mem_req, 1'b0);
      chkb("wait_ready", pc_ready, 1'b0);
    end
    mem_rvalid     = 1'b1;
    mem_rdata      = mem_word(a0);
    buf_invalidate = inval_fill;
    @(posedge clk); #1;
    mem_rvalid     = 1'b0;
    buf_invalidate = 1'b0;
    chkb("fill_valid", inst_valid_out, !flush_wait);
    chkb("ready_back", pc_ready, 1'b1);
  endtask

  vec_t vt[8];

  initial begin
    vt[0] = '{32'h2000_0000, 1'b0, 0, 1, 16'h1234};
    vt[1] = '{32'h2000_0002, 1'b1, 0, 0, 16'hBEEF};
    vt[2] = '{32'h2000_0000, 1'b1, 0, 0, 16'h1234};
    vt[3] = '{32'h2000_0101, 1'b0, 4, 2, 16'h9BDF};
    vt[4] = '{32'h2000_0102, 1'b1, 0, 0, 16'h1357};
    vt[5] = '{32'h2000_0002, 1'b0, 1, 3, 16'hBEEF};
    vt[6] = '{32'h2000_0020, 1'b0, 2, 1, 16'hF00D};
    vt[7] = '{32'h2000_0022, 1'b1, 0, 0, 16'h0BAD};

    reset = 1'b1; pc_in = '0; pc_valid = 1'b0; flush = 1'b0; buf_invalidate = 1'b0;
    mem_ready = 1'b0; mem_rdata = '0; mem_rvalid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chkb("rst_pc_ready", pc_ready, 1'b0);
    chkb("rst_valid", inst_valid_out, 1'b0);
    chk("rst_data", {16'b0, inst_data_out}, 32'h0);
    chk("rst_addr", inst_addr_out, 32'h0);
    chkb("rst_mem_req", mem_req, 1'b0);
    chk("rst_mem_addr", mem_addr, 32'h0);
    reset = 1'b0;
    @(posedge clk); #1;
    chkb("idle_ready", pc_ready, 1'b1);

    for (int i = 0; i < 8; i++)
      fetch(vt[i].pc, vt[i].hit, vt[i].rdly, vt[i].rvdly, 1'b0, 1'b0, vt[i].data);

    // Back-to-back hits at one instruction per cycle.
    pc_in = 32'h2000_0020; pc_valid = 1'b1;
    sb.push_back('{16'hF00D, 32'h2000_0020});
    @(posedge clk); #1;
    chkb("b2b_first", inst_valid_out, 1'b1);
    pc_in = 32'h2000_0022;
    sb.push_back('{16'h0BAD, 32'h2000_0022});
    @(posedge clk); #1;
    chkb("b2b_second", inst_valid_out, 1'b1);
    pc_valid = 1'b0;
    @(posedge clk); #1;
    chkb("b2b_pulse_end", inst_valid_out, 1'b0);

    // Invalidate with an IDLE hit: old data served, next access misses.
    pc_in = 32'h2000_0020; pc_valid = 1'b1; buf_invalidate = 1'b1;
    sb.push_back('{16'hF00D, 32'h2000_0020});
    @(posedge clk); #1;
    pc_valid = 1'b0; buf_invalidate = 1'b0;
    chkb("inval_hit_served", inst_valid_out, 1'b1);
    fetch(32'h2000_0022, 1'b0, 0, 1, 1'b0, 1'b0, 16'h0BAD);

    // Flush in WAIT: no output, but the buffer fills.
    fetch(32'h2000_0030, 1'b0, 1, 3, 1'b1, 1'b0, 16'h0030);
    fetch(32'h2000_0032, 1'b1, 0, 0, 1'b0, 1'b0, 16'hA5A5);

    // Invalidate coincident with fill: delivered, then the word misses again.
    fetch(32'h2000_0010, 1'b0, 0, 2, 1'b0, 1'b1, 16'h5678);
    fetch(32'h2000_0012, 1'b0, 0, 1, 1'b0, 1'b0, 16'hCAFE);

    // Flush coincident with a request in IDLE: not accepted.
    pc_in = 32'h2000_0050; pc_valid = 1'b1; flush = 1'b1;
    @(posedge clk); #1;
    pc_valid = 1'b0; flush = 1'b0;
    chkb("idle_flush_no_req", mem_req, 1'b0);
    chkb("idle_flush_no_valid", inst_valid_out, 1'b0);
    chkb("idle_flush_ready", pc_ready, 1'b1);

    // Reset while in REQ, then a stray response.
    pc_in = 32'h2000_0040; pc_valid = 1'b1;
    @(posedge clk); #1;
    pc_valid = 1'b0;
    chkb("rreq_req_high", mem_req, 1'b1);
    reset = 1'b1;
    @(posedge clk); #1;
    chkb("rreq_req_drop", mem_req, 1'b0);
    chkb("rreq_ready_low", pc_ready, 1'b0);
    chk("rreq_mem_addr", mem_addr, 32'h0);
    reset = 1'b0;
    @(posedge clk); #1;
    mem_rvalid = 1'b1; mem_rdata = 32'h7777_8888;
    @(posedge clk); #1;
    mem_rvalid = 1'b0;
    chkb("stray_no_valid", inst_valid_out, 1'b0);
    chkb("stray_no_req", mem_req, 1'b0);
    fetch(32'h2000_0002, 1'b0, 0, 1, 1'b0, 1'b0, 16'hBEEF);
    fetch(32'h2000_0040, 1'b0, 0, 1, 1'b0, 1'b0, 16'h0040);

    repeat (3) @(posedge clk);
    #1;
    chk("sb_empty", sb.size(), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/w0rm_core_imem_port.md
# w0rm_core_imem_port

Instruction-side memory responder for the W0RM core. It accepts halfword-aligned PC requests from the instruction fetch stage and returns one 16-bit instruction per request with its address and a valid strobe. A single-word line buffer serves back-to-back halfwords from the same 32-bit word. Misses go out over a simple request/response bus to instruction memory, and in-flight results are discarded on a branch flush.

## Interface
- ADDR_WIDTH, 32, PC and bus address width.
- DATA_WIDTH, 32, memory word width; fixed at 32.
- INST_WIDTH, 16, instruction width; fixed at 16.
- clk  in  1  clock.
- reset  in  1  synchronous, active-high.
- pc_in  in  ADDR_WIDTH  requested instruction address; bit 0 ignored.
- pc_valid  in  1  request strobe; sampled only while pc_ready is high.
- pc_ready  out  1  high only in IDLE and with reset low.
- flush  in  1  branch flush; cancels the output for any outstanding request.
- buf_invalidate  in  1  clears the line buffer (instruction-memory write).
- inst_data_out  out  INST_WIDTH  returned instruction.
- inst_valid_out  out  1  single-cycle strobe; no backpressure.
- inst_addr_out  out  ADDR_WIDTH  address of inst_data_out, with bit 0 = 0.
- mem_req  out  1  bus read request.
- mem_addr  out  ADDR_WIDTH  word-aligned read address; bits [1:0] = 0.
- mem_ready  in  1  bus accepts the request this cycle.
- mem_rdata  in  DATA_WIDTH  read data.
- mem_rvalid  in  1  read data valid.

## Operation
- Line buffer contents:
  - buf_tag = pc[ADDR_WIDTH-1:2].
  - buf_data = 32 bits.
  - buf_valid = 1 bit.
- Halfword select is little-endian: pc[1]=0 selects word[15:0]; pc[1]=1 selects word[31:16].
- FSM states: IDLE, REQ, WAIT.
- IDLE, pc_valid with hit (buf_valid and tag match):
  - Registers data, address and valid.
  - Stays in IDLE.
- IDLE, pc_valid with miss:
  - Latches pc.
  - Sets mem_addr = {pc[ADDR_WIDTH-1:2], 2'b00}.
  - Goes to REQ.
- REQ:
  - mem_req=1, and mem_addr is held stable until mem_ready.
  - mem_req && mem_ready goes to WAIT.
  - A request cannot be withdrawn once raised.
- WAIT:
  - mem_rvalid writes buf_data and buf_tag and sets buf_valid.
  - On the same edge the selected halfword is registered to the outputs; go to IDLE.
  - mem_rvalid is ignored outside WAIT.
- Flush:
  - Flush in REQ or WAIT sets a drop flag.
  - The transaction completes normally and the buffer still fills.
  - inst_valid_out is suppressed for that response.
  - The drop flag clears on return to IDLE.
- Flush in IDLE coincident with pc_valid: the request is not accepted and no output is produced.
- buf_invalidate:
  - Clears buf_valid next edge.
  - If it coincides with a WAIT fill, invalidate wins: buf_valid=0, but the instruction is still delivered (subject to flush).
  - If it coincides with an IDLE hit, the hit is served from the old data.
- Reset:
  - State IDLE, buf_valid=0, drop flag=0.
  - inst_valid_out=0, inst_data_out=0, inst_addr_out=0.
  - mem_req=0, mem_addr=0.
  - pc_ready=0 while reset is high.
- Reset mid-transaction:
  - Abandons the transaction and returns to IDLE.
  - A late mem_rvalid after reset is ignored because the state is IDLE.

## Timing
- Hit latency: pc_valid at edge N gives inst_valid_out high during cycle N+1. Back-to-back hits sustain 1 instruction/cycle.
- Miss timing:
  - pc_valid at N gives mem_req high from N+1.
  - Acceptance at edge A moves to WAIT.
  - mem_rvalid at edge K (K > A) gives inst_valid_out during K+1.
  - pc_ready is low from N+1 through K and high again at K+1.
- Minimum miss latency is 3 cycles: mem_ready at N+1 and mem_rvalid at N+2 give the output at N+3.
- inst_valid_out is a one-cycle pulse; inst_data_out and inst_addr_out hold their values until the next strobe.
- pc_ready is combinational from state and reset only.

## Test plan
- Reset, then pc_in=0x2000_0000 (miss):
  - mem_addr=0x2000_0000 with mem_req high.
  - Bus returns 0xBEEF_1234 one cycle after ready.
  - inst_data_out=0x1234 and inst_addr_out=0x2000_0000, 3 cycles after the request.
- Follow-up hit: pc_in=0x2000_0002 next cycle gives 0xBEEF at 0x2000_0002 one cycle later, with no mem_req.
- Stalled bus: mem_ready held low 4 cycles, then rvalid 2 cycles later:
  - mem_req and mem_addr stay stable throughout.
  - pc_ready stays low.
  - Exactly one inst_valid_out pulse.
- Flush in WAIT:
  - No inst_valid_out.
  - A next request to the same word hits with 1-cycle latency.
- buf_invalidate coincident with the fill of 0x2000_0010:
  - The instruction is still delivered.
  - A subsequent pc_in=0x2000_0012 misses and re-issues mem_req.
- Reset asserted in REQ:
  - mem_req drops next cycle.
  - A stray mem_rvalid afterward produces no inst_valid_out and no buffer fill.
